// File: rtl/nnrv_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nnrv_mmio_pkg
//  Description : Register map, CTRL/STATUS bit positions and byte-lane mask
//                expansion shared by the MMIO responder and its timer.
//  Revision    : 1.0  initial release
// ============================================================================
package nnrv_mmio_pkg;

   localparam int PKG_XLEN       = 64;
   localparam int PKG_MASK_WIDTH = 8;

   // Register index (addr[5:3])
   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_MTIME    = 3'd1;
   localparam logic [2:0] REG_MTIMECMP = 3'd2;
   localparam logic [2:0] REG_STATUS   = 3'd3;
   localparam logic [2:0] REG_SCRATCH  = 3'd4;

   // CTRL bit positions
   localparam int CTRL_TIMER_EN = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_LED      = 2;
   localparam int CTRL_WIDTH    = 3;

   // STATUS bit positions
   localparam int STATUS_PENDING = 0;

   // Each mask bit k becomes eight ones covering byte lane k.
   function automatic logic [PKG_XLEN-1:0] expand_mask(input logic [PKG_MASK_WIDTH-1:0] mask);
      logic [PKG_XLEN-1:0] bm;
      bm = '0;
      for (int k = 0; k < PKG_MASK_WIDTH; k++) begin
         bm[k*8 +: 8] = {8{mask[k]}};
      end
      return bm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nnrv_mmio_timer.sv
`default_nettype none
// ============================================================================
//  Module      : nnrv_mmio_timer
//  Description : Prescaler, 64-bit MTIME, MTIMECMP and the pending flag.
//                Writes arrive as bit-level lane masks already decoded.
//  Revision    : 1.0  initial release
// ============================================================================
module nnrv_mmio_timer #(
   parameter int XLEN     = 64,
   parameter int PRESCALE = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_timer_en,
   input  logic [XLEN-1:0] i_wr_data,
   input  logic [XLEN-1:0] i_mtime_bm,
   input  logic [XLEN-1:0] i_mtimecmp_bm,
   input  logic            i_clr_pending,
   output logic [XLEN-1:0] o_mtime,
   output logic [XLEN-1:0] o_mtimecmp,
   output logic            o_pending
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(PRESCALE - 1);
   localparam logic [XLEN-1:0]  c_one     = {{(XLEN-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_mtime;
   logic [XLEN-1:0]  r_mtimecmp;
   logic             r_pending;
   logic             w_tick;
   logic             w_cmp;

   assign w_tick = i_timer_en && (r_cnt == c_cnt_max);
   assign w_cmp  = i_timer_en && (r_mtime >= r_mtimecmp);

   // Prescale counter: runs only while the timer is enabled.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)          r_cnt <= '0;
      else if (w_tick)     r_cnt <= '0;
      else if (i_timer_en) r_cnt <= r_cnt + CNT_W'(1);
   end

   // MTIME: any lane write suppresses that cycle's increment entirely.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)             r_mtime <= '0;
      else if (|i_mtime_bm)   r_mtime <= (r_mtime & ~i_mtime_bm) | (i_wr_data & i_mtime_bm);
      else if (w_tick)        r_mtime <= r_mtime + c_one;
   end

   // MTIMECMP resets to all ones so no interrupt fires before software sets it.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_mtimecmp <= '1;
      else        r_mtimecmp <= (r_mtimecmp & ~i_mtimecmp_bm) | (i_wr_data & i_mtimecmp_bm);
   end

   // Pending: a live compare beats a same-cycle write-1-to-clear.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)             r_pending <= 1'b0;
      else if (w_cmp)         r_pending <= 1'b1;
      else if (i_clr_pending) r_pending <= 1'b0;
   end

   assign o_mtime    = r_mtime;
   assign o_mtimecmp = r_mtimecmp;
   assign o_pending  = r_pending;

endmodule
`default_nettype wire

// File: rtl/nnrv_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : nnrv_mmio
//  Description : Data-side MMIO responder: 64-byte window with CTRL, MTIME,
//                MTIMECMP, STATUS and SCRATCH; drives LED and timer IRQ.
//  Revision    : 1.0  initial release
// ============================================================================
module nnrv_mmio
   import nnrv_mmio_pkg::*;
#(
   parameter int                    XLEN       = 64,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    MASK_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 10'h3C0,
   parameter int                    PRESCALE   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   input  logic                  i_rd_en,
   input  logic [MASK_WIDTH-1:0] i_rd_mask,
   output logic [XLEN-1:0]       o_rd_data,
   output logic                  o_rd_hit,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic                  i_wr_en,
   input  logic [MASK_WIDTH-1:0] i_wr_mask,
   input  logic [XLEN-1:0]       i_wr_data,
   output logic                  o_irq,
   output logic                  o_led
);

   logic                  w_rd_hit;
   logic                  w_wr_hit;
   logic [2:0]            w_rd_idx;
   logic [2:0]            w_wr_idx;
   logic                  w_wr_sel;
   logic [XLEN-1:0]       w_wr_bm;
   logic [XLEN-1:0]       w_rd_val;
   logic [XLEN-1:0]       w_mtime;
   logic [XLEN-1:0]       w_mtimecmp;
   logic                  w_pending;
   logic                  w_clr_pending;
   logic [CTRL_WIDTH-1:0] r_ctrl;
   logic [XLEN-1:0]       r_scratch;
   logic [XLEN-1:0]       r_rd_data;
   logic                  r_rd_hit;

   // Byte offset within a register is irrelevant to decode.
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, i_rd_addr[2:0], i_wr_addr[2:0]};

   assign w_rd_hit = i_rd_addr[ADDR_WIDTH-1:6] == BASE_ADDR[ADDR_WIDTH-1:6];
   assign w_wr_hit = i_wr_addr[ADDR_WIDTH-1:6] == BASE_ADDR[ADDR_WIDTH-1:6];
   assign w_rd_idx = i_rd_addr[5:3];
   assign w_wr_idx = i_wr_addr[5:3];
   assign w_wr_sel = i_wr_en && w_wr_hit;
   assign w_wr_bm  = expand_mask(i_wr_mask);

   assign w_clr_pending = w_wr_sel && (w_wr_idx == REG_STATUS) &&
                          i_wr_mask[0] && i_wr_data[STATUS_PENDING];

   nnrv_mmio_timer #(
      .XLEN     (XLEN),
      .PRESCALE (PRESCALE)
   ) u_timer (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_timer_en    (r_ctrl[CTRL_TIMER_EN]),
      .i_wr_data     (i_wr_data),
      .i_mtime_bm    ((w_wr_sel && w_wr_idx == REG_MTIME)    ? w_wr_bm : '0),
      .i_mtimecmp_bm ((w_wr_sel && w_wr_idx == REG_MTIMECMP) ? w_wr_bm : '0),
      .i_clr_pending (w_clr_pending),
      .o_mtime       (w_mtime),
      .o_mtimecmp    (w_mtimecmp),
      .o_pending     (w_pending)
   );

   // CTRL lives entirely in byte lane 0.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         r_ctrl <= '0;
      else if (w_wr_sel && (w_wr_idx == REG_CTRL) && i_wr_mask[0])
         r_ctrl <= i_wr_data[CTRL_WIDTH-1:0];
   end

   // SCRATCH: plain lane-masked storage.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         r_scratch <= '0;
      else if (w_wr_sel && (w_wr_idx == REG_SCRATCH))
         r_scratch <= (r_scratch & ~w_wr_bm) | (i_wr_data & w_wr_bm);
   end

   // Read mux over current (pre-write) register values.
   always_comb begin
      w_rd_val = '0;
      case (w_rd_idx)
         REG_CTRL:     w_rd_val = {{(XLEN-CTRL_WIDTH){1'b0}}, r_ctrl};
         REG_MTIME:    w_rd_val = w_mtime;
         REG_MTIMECMP: w_rd_val = w_mtimecmp;
         REG_STATUS:   w_rd_val = {{(XLEN-1){1'b0}}, w_pending};
         REG_SCRATCH:  w_rd_val = r_scratch;
         default:      w_rd_val = '0;
      endcase
   end

   // Registered read port; misses return zero so the top can OR/mux freely.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_rd_data <= '0;
         r_rd_hit  <= 1'b0;
      end else if (i_rd_en && w_rd_hit) begin
         r_rd_data <= w_rd_val & expand_mask(i_rd_mask);
         r_rd_hit  <= 1'b1;
      end else begin
         r_rd_data <= '0;
         r_rd_hit  <= 1'b0;
      end
   end

   assign o_rd_data = r_rd_data;
   assign o_rd_hit  = r_rd_hit;
   assign o_irq     = w_pending & r_ctrl[CTRL_IRQ_EN];
   assign o_led     = r_ctrl[CTRL_LED];

endmodule
`default_nettype wire

// File: tb/tb_nnrv_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nnrv_mmio
//  Description : Directed self-checking bench for nnrv_mmio.
//                Stimulus changes just after a falling edge; outputs are
//                observed at the following falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nnrv_mmio;

   localparam logic [9:0] A_CTRL    = 10'h3C0;
   localparam logic [9:0] A_MTIME   = 10'h3C8;
   localparam logic [9:0] A_CMP     = 10'h3D0;
   localparam logic [9:0] A_STATUS  = 10'h3D8;
   localparam logic [9:0] A_SCRATCH = 10'h3E0;
   localparam logic [9:0] A_UNMAP   = 10'h3E8;
   localparam logic [9:0] A_BELOW   = 10'h3B8;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic        rd_en;
   logic [7:0]  rd_mask;
   logic [63:0] rd_data;
   logic        rd_hit;
   logic [9:0]  wr_addr;
   logic        wr_en;
   logic [7:0]  wr_mask;
   logic [63:0] wr_data;
   logic        irq;
   logic        led;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   nnrv_mmio #(
      .XLEN       (64),
      .ADDR_WIDTH (10),
      .MASK_WIDTH (8),
      .BASE_ADDR  (10'h3C0),
      .PRESCALE   (1)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_rd_addr (rd_addr),
      .i_rd_en   (rd_en),
      .i_rd_mask (rd_mask),
      .o_rd_data (rd_data),
      .o_rd_hit  (rd_hit),
      .i_wr_addr (wr_addr),
      .i_wr_en   (wr_en),
      .i_wr_mask (wr_mask),
      .i_wr_data (wr_data),
      .o_irq     (irq),
      .o_led     (led)
   );

   // One write over one rising edge; called and returns at a falling edge.
   task automatic do_write(input logic [9:0] a, input logic [7:0] m, input logic [63:0] d);
      wr_addr = a; wr_mask = m; wr_data = d; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // One read over one rising edge; result visible on return.
   task automatic do_read(input logic [9:0] a, input logic [7:0] m);
      rd_addr = a; rd_mask = m; rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      n_tests++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_rd_hit: got %b expected 0", rd_hit); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
      n_tests++; if (led !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b expected 0", led); end
      rst = 1'b1;
      do_read(A_MTIME, 8'hFF);
      n_tests++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_mtime: got %h expected 0", rd_data); end
      n_tests++; if (rd_hit !== 1'b1) begin n_fail++; $display("FAIL reset_mtime_hit: got %b expected 1", rd_hit); end
      do_read(A_CMP, 8'hFF);
      n_tests++; if (rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL reset_mtimecmp: got %h expected ffffffffffffffff", rd_data); end
      n_tests++; if (rd_hit !== 1'b1) begin n_fail++; $display("FAIL reset_mtimecmp_hit: got %b expected 1", rd_hit); end
   endtask

   task automatic test_scratch();
      do_write(A_SCRATCH, 8'hFF, 64'h1122_3344_5566_7788);
      do_write(A_SCRATCH, 8'h01, 64'h0000_0000_0000_00AA);
      do_read(A_SCRATCH, 8'h0F);
      n_tests++; if (rd_data !== 64'h0000_0000_5566_77AA) begin n_fail++; $display("FAIL scratch_masked: got %h expected 00000000556677aa", rd_data); end
      do_read(A_SCRATCH | 10'h5, 8'hFF);
      n_tests++; if (rd_data !== 64'h1122_3344_5566_77AA) begin n_fail++; $display("FAIL scratch_low_addr: got %h expected 11223344556677aa", rd_data); end
      do_read(A_BELOW, 8'hFF);
      n_tests++; if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b expected 0", rd_hit); end
      n_tests++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL miss_data: got %h expected 0", rd_data); end
      do_write(A_UNMAP, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      do_read(A_UNMAP, 8'hFF);
      n_tests++; if (rd_data !== 64'h0 || rd_hit !== 1'b1) begin n_fail++; $display("FAIL unmapped: got data %h hit %b expected 0 hit 1", rd_data, rd_hit); end
   endtask

   task automatic test_led();
      do_write(A_CTRL, 8'hFF, 64'h4);
      n_tests++; if (led !== 1'b1) begin n_fail++; $display("FAIL led_on: got %b expected 1", led); end
      do_write(A_CTRL, 8'hFF, 64'h0);
      n_tests++; if (led !== 1'b0) begin n_fail++; $display("FAIL led_off: got %b expected 0", led); end
      // Bits above 2 are not stored; timer bits stay clear.
      do_write(A_CTRL, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFC);
      do_read(A_CTRL, 8'hFF);
      n_tests++; if (rd_data !== 64'h4) begin n_fail++; $display("FAIL ctrl_readback: got %h expected 4", rd_data); end
      do_write(A_CTRL, 8'hFE, 64'h0);
      n_tests++; if (led !== 1'b1) begin n_fail++; $display("FAIL ctrl_lane0_masked: got %b expected 1", led); end
      do_write(A_CTRL, 8'h01, 64'h0);
   endtask

   task automatic test_back_to_back();
      // Read and write SCRATCH on the same edge: read sees the old value.
      rd_addr = A_SCRATCH; rd_mask = 8'hFF; rd_en = 1'b1;
      wr_addr = A_SCRATCH; wr_mask = 8'hFF; wr_data = 64'hDEAD_BEEF_0000_0001; wr_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      n_tests++; if (rd_data !== 64'h1122_3344_5566_77AA) begin n_fail++; $display("FAIL rw_same_cycle: got %h expected 11223344556677aa", rd_data); end
      do_read(A_SCRATCH, 8'hFF);
      n_tests++; if (rd_data !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL rw_after: got %h expected deadbeef00000001", rd_data); end
   endtask

   task automatic test_irq();
      do_write(A_CMP, 8'hFF, 64'h5);
      do_write(A_CTRL, 8'h01, 64'h3);
      // MTIME is 0 here and counts 1..5 over the next five edges.
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
      end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b expected 0", irq); end
      @(negedge clk);
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", irq); end
      do_write(A_STATUS, 8'h01, 64'h1);
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_set_wins: got %b expected 1", irq); end
      do_read(A_STATUS, 8'hFF);
      n_tests++; if (rd_data !== 64'h1) begin n_fail++; $display("FAIL status_read: got %h expected 1", rd_data); end
      do_write(A_CMP, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      do_write(A_STATUS, 8'h01, 64'h1);
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_clear: got %b expected 0", irq); end
   endtask

   task automatic test_wrap();
      do_write(A_MTIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      // Timer still enabled on this edge: MTIME wraps to 0, then stops.
      do_write(A_CTRL, 8'h01, 64'h0);
      do_read(A_MTIME, 8'hFF);
      n_tests++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL mtime_wrap: got %h expected 0", rd_data); end
      do_write(A_STATUS, 8'h01, 64'h1);
      do_read(A_STATUS, 8'hFF);
      n_tests++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL status_cleared: got %h expected 0", rd_data); end
   endtask

   task automatic test_lane_inc();
      do_write(A_MTIME, 8'hFF, 64'h0102_0304_0506_07FF);
      do_write(A_CTRL, 8'h01, 64'h1);
      // Increment would carry into lane1; the lane0 write suppresses it.
      do_write(A_MTIME, 8'h01, 64'hEEEE_EEEE_EEEE_EE55);
      rd_addr = A_MTIME; rd_mask = 8'hFF; rd_en = 1'b1;
      wr_addr = A_CTRL; wr_mask = 8'h01; wr_data = 64'h0; wr_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      n_tests++; if (rd_data !== 64'h0102_0304_0506_0755) begin n_fail++; $display("FAIL lane_write_inc: got %h expected 0102030405060755", rd_data); end
   endtask

   task automatic test_async_reset();
      do_write(A_CMP, 8'hFF, 64'h0);
      do_write(A_CTRL, 8'h01, 64'h7);
      do_read(A_SCRATCH, 8'hFF);
      n_tests++; if (irq !== 1'b1 || led !== 1'b1) begin n_fail++; $display("FAIL pre_reset_outputs: got irq %b led %b expected 1 1", irq, led); end
      n_tests++; if (rd_data !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL pre_reset_rd: got %h expected deadbeef00000001", rd_data); end
      #2 rst = 1'b0;
      #1;
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL async_irq: got %b expected 0", irq); end
      n_tests++; if (led !== 1'b0) begin n_fail++; $display("FAIL async_led: got %b expected 0", led); end
      n_tests++; if (rd_data !== 64'h0 || rd_hit !== 1'b0) begin n_fail++; $display("FAIL async_rd: got %h hit %b expected 0 0", rd_data, rd_hit); end
      @(negedge clk);
      rst = 1'b1;
      do_read(A_CMP, 8'hFF);
      n_tests++; if (rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL post_reset_cmp: got %h expected ffffffffffffffff", rd_data); end
      do_read(A_SCRATCH, 8'hFF);
      n_tests++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL post_reset_scratch: got %h expected 0", rd_data); end
   endtask

   initial begin
      rst = 1'b0;
      rd_addr = '0; rd_en = 1'b0; rd_mask = '0;
      wr_addr = '0; wr_en = 1'b0; wr_mask = '0; wr_data = '0;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      test_scratch();
      test_led();
      test_back_to_back();
      test_irq();
      test_wrap();
      test_lane_inc();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nnrv_mmio.md
Name: nnrv_mmio

Overview:
Memory-mapped peripheral responder on the core's data-side RAM port (the rd2/wr channel driven by the mem stage).
- Decodes a 64-byte window at BASE_ADDR.
- Serves control, 64-bit timer, compare, status and scratch registers with byte-lane masks.
- Drives the board LED and a timer interrupt line.
- Sits beside ram; the top muxes read data using o_rd_hit.

Parameters:
XLEN, 64, data width of the register port
ADDR_WIDTH, 10, byte-address width seen by the port
MASK_WIDTH, 8, byte-lane mask width (XLEN/8)
BASE_ADDR, 10'h3C0, window base; must be 64-byte aligned
PRESCALE, 1, core clocks per mtime increment (>=1)

Ports:
i_clk  in  1  core clock, rising edge
i_rst  in  1  asynchronous reset, active-low
i_rd_addr  in  ADDR_WIDTH  read byte address
i_rd_en  in  1  read request
i_rd_mask  in  MASK_WIDTH  read byte lanes
o_rd_data  out  XLEN  read data, registered
o_rd_hit  out  1  registered: previous-cycle read hit the window
i_wr_addr  in  ADDR_WIDTH  write byte address
i_wr_en  in  1  write request
i_wr_mask  in  MASK_WIDTH  write byte lanes
i_wr_data  in  XLEN  write data
o_irq  out  1  timer interrupt
o_led  out  1  LED drive

Behaviour:
- Hit: addr[ADDR_WIDTH-1:6] == BASE_ADDR[ADDR_WIDTH-1:6]. Register index is addr[5:3]; addr[2:0] is ignored.
- Register map:
  - 0 CTRL: bit0 timer_en, bit1 irq_en, bit2 led; other bits read 0.
  - 1 MTIME
  - 2 MTIMECMP
  - 3 STATUS: bit0 pending, write-1-to-clear.
  - 4 SCRATCH
  - 5-7 unmapped: read 0, writes ignored.
- Reset (i_rst low, async): CTRL=0, MTIME=0, MTIMECMP=all ones, pending=0, SCRATCH=0, prescale count=0, o_rd_data=0, o_rd_hit=0, o_irq=0, o_led=0.
- Read timing: 1-cycle latency.
  - On the edge where i_rd_en=1 and hit: o_rd_data <= reg value AND byte-expanded i_rd_mask; o_rd_hit <= 1.
  - Otherwise o_rd_data <= 0 and o_rd_hit <= 0.
- Write: on the edge where i_wr_en=1 and hit, each byte lane k with i_wr_mask[k]=1 updates. STATUS: writing 1 to byte0 bit0 clears pending.
- Read and write to the same register in the same cycle: read returns the pre-write value.
- Prescaler: count increments when timer_en=1. When count == PRESCALE-1: count <= 0 and MTIME <= MTIME+1 (mod 2^64, wraps to 0). With timer_en=0, count and MTIME hold.
- Write vs. increment to MTIME in the same cycle: lanes written take the written bytes; unwritten lanes keep the old value (no increment applied that cycle).
- Compare: cmp = timer_en & (MTIME >= MTIMECMP), unsigned, using current register values.
  - pending <= 1 when cmp.
  - W1C with cmp true the same cycle: set wins, pending stays 1.
- Outputs: o_irq = pending & irq_en (combinational from flops); o_led = CTRL bit2.
- Reset asserted mid-operation: everything returns to reset values immediately; no partial write survives.

Decomposition:
- Package nnrv_mmio_pkg: register index constants (REG_CTRL=0 ... REG_SCRATCH=4), CTRL bit positions, STATUS_PENDING bit, function expanding MASK_WIDTH lanes to an XLEN bit mask.
- One sub-module is natural: nnrv_mmio_timer (prescaler, MTIME, MTIMECMP, pending; takes decoded lane-write strobes, outputs values and pending). The top keeps decode, CTRL, SCRATCH and the read mux.

Test Plan:
- Reset with i_rst low, then release; read idx1 and idx2 with full mask -> o_rd_data 0 and 64'hFFFF_FFFF_FFFF_FFFF one cycle later, o_rd_hit=1.
- Write SCRATCH 64'h1122334455667788 mask 8'hFF, then write 64'hAA mask 8'h01, read mask 8'h0F -> 64'h00000000556677AA; read at BASE_ADDR-8 -> o_rd_hit=0, data 0.
- Write CTRL=4 -> o_led=1 next cycle; write CTRL=0 -> o_led=0.
- PRESCALE=1, MTIMECMP=5, CTRL=3 -> pending and o_irq rise on the edge after MTIME reaches 5.
  - W1C to STATUS while MTIME>=5 -> pending stays 1.
  - Set MTIMECMP=all ones, then W1C -> o_irq=0.
- MTIME write 64'hFFFF_FFFF_FFFF_FFFF with timer_en=1 -> next cycle it reads 0 (wrap).
  - Write lanes 8'h01 of MTIME during an increment cycle -> lane0 gets the new byte, upper lanes keep the old value.
- Assert i_rst low mid-count with o_irq=1 -> o_irq, o_led and o_rd_data drop to 0 immediately, without waiting for a clock edge.
